// File: rtl/sbox_word_stage.sv
// sbox_word_stage
//   Two-stage pipelined 32-bit SubWord stage. It feeds the AES datapath and the
//   key-schedule consumers.
//   Stage 1 accepts a word and registers it. For key-schedule words it applies
//   RotWord first. Stage 2 passes all four bytes through the forward or inverse
//   S-box. A key-schedule word then has its byte0 XORed with the Rcon value it
//   captured when it was accepted. Both sides use a valid/ready handshake, and
//   the stage sustains one word per cycle.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_ready        input handshake
//   in_data, in_inv, in_ks   input word, inverse select, key-schedule op
//   in_tag                   opaque sideband carried with the word
//   rcon_clr                 synchronous reload of Rcon to RCON_INIT
//   out_valid/out_ready      output handshake
//   out_data, out_tag        result word and its tag
//   rcon_o                   current Rcon register value

// sbox_core
//   Combinational AES S-box with an inverse select. The external bit map is
//   MSB-first (u0 = b[7] ... u7 = b[0], o0 = res[7] ... o7 = res[0]). That is
//   ordinary byte order, so the byte passes straight through.
//   Ports: u_i input byte, inv_i 0 = forward / 1 = inverse, o_o result byte.
//   The S-box is computed as GF(2^8) inversion plus the affine map. This keeps
//   the source free of a 256-entry table. Forward is affine(inv(x)); inverse is
//   inv(affine^-1(x)).
module sbox_core (
  input  logic [7:0] u_i,
  input  logic       inv_i,
  output logic [7:0] o_o
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xt(s);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  // x^254 is the multiplicative inverse, and it maps 0 to 0 as the S-box needs.
  // Exponent chain: 2, 3, 6, 12, 15, 30, 60, 120, 240, then 240 + 12 + 2.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_sq(x);
    x3   = gf_mul(x2, x);
    x6   = gf_sq(x3);
    x12  = gf_sq(x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_sq(x15);
    x60  = gf_sq(x30);
    x120 = gf_sq(x60);
    x240 = gf_sq(x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // s_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, written as left rotations
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // b_i = s_(i+2) ^ s_(i+5) ^ s_(i+7) ^ d_i
  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] pre;
  logic [7:0] g;

  always_comb begin
    pre = inv_i ? inv_affine(u_i) : u_i;
    g   = gf_inv(pre);
    o_o = inv_i ? g : affine(g);
  end

endmodule

module sbox_word_stage #(
  parameter int         TAG_W     = 2,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_inv,
  input  logic             in_ks,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             rcon_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       rcon_o
);

  // stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      w1_q, w1_d;
  logic             inv1_q, inv1_d;
  logic             ks1_q, ks1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic [7:0]       rc1_q, rc1_d;

  // stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      res_q, res_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic [7:0]       rcon_q, rcon_d;

  logic             accept;
  logic             s1_adv;
  logic [31:0]      sub_w;

  // in_ready depends only on occupancy and out_ready, never on in_valid.
  // When stage 1 is full, it can still take a word in the same cycle that
  // its current word moves on to stage 2.
  assign in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);

  for (genvar k = 0; k < 4; k++) begin : g_sbox
    sbox_core u_sbox (
      .u_i   (w1_q[8*k +: 8]),
      .inv_i (inv1_q),
      .o_o   (sub_w[8*k +: 8])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    w1_d       = w1_q;
    inv1_d     = inv1_q;
    ks1_d      = ks1_q;
    tag1_d     = tag1_q;
    rc1_d      = rc1_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      // RotWord: the new byte0 is the old byte1, and the old byte0 wraps to byte3
      w1_d       = in_ks ? {in_data[7:0], in_data[31:8]} : in_data;
      inv1_d     = in_inv & ~in_ks;
      ks1_d      = in_ks;
      tag1_d     = in_tag;
      rc1_d      = rcon_q;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    tag2_d     = tag2_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      res_d      = sub_w ^ {24'h000000, (ks1_q ? rc1_q : 8'h00)};
      tag2_d     = tag1_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // A reload wins over an advance. The word accepted in the same cycle has
  // already captured the old Rcon in rc1.
  always_comb begin
    rcon_d = rcon_q;
    if (rcon_clr) begin
      rcon_d = RCON_INIT;
    end else if (accept && in_ks) begin
      rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      w1_q       <= '0;
      inv1_q     <= 1'b0;
      ks1_q      <= 1'b0;
      tag1_q     <= '0;
      rc1_q      <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      tag2_q     <= '0;
      rcon_q     <= RCON_INIT;
    end else begin
      s1_valid_q <= s1_valid_d;
      w1_q       <= w1_d;
      inv1_q     <= inv1_d;
      ks1_q      <= ks1_d;
      tag1_q     <= tag1_d;
      rc1_q      <= rc1_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      tag2_q     <= tag2_d;
      rcon_q     <= rcon_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = res_q;
  assign out_tag   = tag2_q;
  assign rcon_o    = rcon_q;

endmodule

// File: tb/tb_sbox_word_stage.sv
// Testbench for sbox_word_stage: directed AES vectors plus randomized traffic,
// checked against a queue-based reference model built from AES arithmetic.
module tb_sbox_word_stage;

  localparam logic [7:0] RCON_INIT = 8'h01;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_inv;
  logic        in_ks;
  logic [1:0]  in_tag;
  logic        rcon_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic [7:0]  rcon_o;

  sbox_word_stage #(.TAG_W(2), .RCON_INIT(RCON_INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .in_ks     (in_ks),
    .in_tag    (in_tag),
    .rcon_clr  (rcon_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .rcon_o    (rcon_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  tag;
    int          acc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [31:0] out_log[$];
  logic [7:0]  fwd_tab[256];
  logic [7:0]  inv_tab[256];
  logic [7:0]  m_rcon;
  int          edge_cnt = 0;
  int          n_pop = 0;
  logic        last_acc;
  logic        s_valid;
  logic [31:0] s_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  // S-box from its definition: brute-force inverse, then the affine matrix bit by bit
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv;
      logic [7:0] s;
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(x[7:0], y[7:0]) == 8'h01) iv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ ((8'h63 >> i) & 1);
      fwd_tab[x] = s;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = x[7:0];
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] d, input logic inv,
                                             input logic ks, input logic [7:0] rc);
    logic [7:0] b[4];
    logic [7:0] o[4];
    for (int k = 0; k < 4; k++) b[k] = d[8*k +: 8];
    for (int k = 0; k < 4; k++) begin
      if (ks)       o[k] = fwd_tab[b[(k+1)%4]];
      else if (inv) o[k] = inv_tab[b[k]];
      else          o[k] = fwd_tab[b[k]];
    end
    if (ks) o[0] = o[0] ^ rc;
    return {o[3], o[2], o[1], o[0]};
  endfunction

  // One clock: sample and check at negedge, update the model at posedge, return at posedge+1
  task automatic drive_cycle();
    logic acc;
    logic pop;
    exp_t e;
    @(negedge clk);
    s_valid = out_valid;
    s_data  = out_data;
    chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    chk("out_valid", out_valid, (q.size() > 0 && q[0].acc < edge_cnt));
    chk("rcon", rcon_o, m_rcon);
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop && q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_tag", out_tag, q[0].tag);
      out_log.push_back(out_data);
      n_pop++;
    end
    @(posedge clk);
    edge_cnt++;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      e.d   = model_word(in_data, in_inv, in_ks, m_rcon);
      e.tag = in_tag;
      e.acc = edge_cnt;
      q.push_back(e);
    end
    if (rcon_clr)          m_rcon = RCON_INIT;
    else if (acc && in_ks) m_rcon = gmul(m_rcon, 8'h02);
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic inv, input logic ks,
                      input logic [1:0] tag, input logic clr);
    int n;
    in_valid = 1'b1; in_data = d; in_inv = inv; in_ks = ks; in_tag = tag; rcon_clr = clr;
    n = 0;
    do begin
      drive_cycle();
      n++;
    end while (!last_acc && n < 50);
    chk("send_timeout", last_acc, 1'b1);
    in_valid = 1'b0; rcon_clr = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; rcon_clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) drive_cycle();
    chk("drain", q.size(), 0);
  endtask

  // Called at posedge+1. Raises reset between edges and checks that outputs clear with no clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tag", out_tag, 2'b00);
    chk("rst_rcon", rcon_o, RCON_INIT);
    chk("rst_in_ready", in_ready, 1'b0);
    q.delete();
    m_rcon = RCON_INIT;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  rc_list[10];
    logic [31:0] orig[$];
    int          sent;
    int          base;
    rc_list = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_ks = 1'b0;
    in_tag = '0; rcon_clr = 1'b0; out_ready = 1'b1; m_rcon = RCON_INIT;
    build_tables();
    do_reset();

    // Forward SubWord, with the latency checked explicitly
    send(32'h53005300, 1'b0, 1'b0, 2'd1, 1'b0);
    drive_cycle();
    chk("fwd_lat_lo", s_valid, 1'b0);
    drive_cycle();
    chk("fwd_lat_hi", s_valid, 1'b1);
    chk("fwd_vec", s_data, 32'hed63ed63);
    drain();

    // Inverse vector
    out_log.delete();
    send(32'hed63ed63, 1'b1, 1'b0, 2'd2, 1'b0);
    drain();
    chk("inv_vec", out_log[0], 32'h53005300);

    // Sweep all 256 bytes forward, then feed the results back through the inverse
    out_log.delete();
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      orig.push_back(w);
      send(w, 1'b0, 1'b0, 2'(i), 1'b0);
    end
    drain();
    base = out_log.size();
    for (int i = 0; i < 64 && i < base; i++) send(out_log[i], 1'b1, 1'b0, 2'(i), 1'b0);
    drain();
    for (int i = 0; i < 64 && base + i < out_log.size(); i++)
      chk("roundtrip", out_log[base+i], orig[i]);
    chk("roundtrip_cnt", out_log.size(), 128);

    // Key-schedule vector (FIPS-197 A.1)
    out_log.delete();
    in_valid = 1'b0; rcon_clr = 1'b1;
    drive_cycle();
    rcon_clr = 1'b0;
    send(32'h3c4fcf09, 1'b1, 1'b1, 2'd3, 1'b0);
    drain();
    chk("ks_vec", out_log[0], 32'h01eb848b);
    chk("ks_rcon", rcon_o, 8'h02);

    // Rcon run after reset; a clear arrives together with the 10th ks word
    do_reset();
    out_log.delete();
    for (int i = 0; i < 10; i++) send(32'h0, 1'b0, 1'b1, 2'(i), (i == 9));
    drain();
    for (int i = 0; i < 10 && i < out_log.size(); i++)
      chk("rcon_run", out_log[i][7:0] ^ 8'h63, rc_list[i]);
    chk("rcon_clr_after", rcon_o, 8'h01);

    // Backpressure: 8 words with random out_ready and a 5-cycle low window
    sent = 0;
    base = n_pop;
    for (int c = 0; c < 200 && sent < 8; c++) begin
      in_valid = 1'b1; in_data = $urandom; in_inv = $urandom_range(0, 1);
      in_ks = 1'b0; in_tag = 2'(sent);
      out_ready = (c >= 2 && c < 7) ? 1'b0 : 1'($urandom_range(0, 1));
      drive_cycle();
      if (last_acc) sent++;
    end
    drain();
    chk("bp_count", n_pop - base, 8);

    // Random mixed traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_inv    = $urandom_range(0, 1);
      in_ks     = ($urandom_range(0, 3) == 0);
      in_tag    = 2'($urandom);
      rcon_clr  = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive_cycle();
    end
    drain();

    // Async reset with two words in flight, then the latency after release
    send(32'h11223344, 1'b0, 1'b1, 2'd1, 1'b0);
    out_ready = 1'b0;
    send(32'h55667788, 1'b0, 1'b0, 2'd2, 1'b0);
    chk("inflight", q.size(), 2);
    do_reset();
    out_ready = 1'b1;
    send(32'h00000053, 1'b0, 1'b0, 2'd3, 1'b0);
    drive_cycle();
    chk("rst_lat_lo", s_valid, 1'b0);
    drive_cycle();
    chk("rst_lat_hi", s_valid, 1'b1);
    chk("rst_word", s_data, 32'h636363ed);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
